// File: rtl/phy_rx_sync_ctrl.sv
// PHY RX sync controller: bit-wise comma hunt, byte alignment, lock sequencing
// and round-robin lane scheduling for the 4-lane demux tree.
module phy_rx_sync_ctrl #(
  parameter logic [7:0] COM        = 8'hBC,
  parameter int         LOCK_COUNT = 4,
  parameter int         WINDOW     = 16
) (
  input  logic       clk_32f,
  input  logic       default_values,
  input  logic       data_in,
  output logic       active,
  output logic       valid,
  output logic [7:0] data_out,
  output logic       byte_strobe,
  output logic [1:0] lane_sel,
  output logic [3:0] com_cnt
);

  localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);
  localparam logic [7:0] WIN8      = 8'(WINDOW);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  state_t     r_state, w_state;
  logic [7:0] r_sh, w_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt;
  logic [7:0] r_window, w_window, w_win_inc;
  logic [3:0] r_com_cnt, w_com_cnt, w_com_inc;
  logic       r_active, w_active;
  logic       r_valid, w_valid;
  logic [7:0] r_data, w_data;
  logic       r_strobe, w_strobe;
  logic [1:0] r_lane, w_lane;
  logic       w_is_com, w_boundary;

  always_ff @(posedge clk_32f) begin
    if (default_values) begin
      r_state   <= HUNT;
      r_sh      <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_window  <= 8'h00;
      r_com_cnt <= 4'd0;
      r_active  <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= 8'h00;
      r_strobe  <= 1'b0;
      r_lane    <= 2'd0;
    end else begin
      r_state   <= w_state;
      r_sh      <= w_nxt;
      r_bit_cnt <= w_bit_cnt;
      r_window  <= w_window;
      r_com_cnt <= w_com_cnt;
      r_active  <= w_active;
      r_valid   <= w_valid;
      r_data    <= w_data;
      r_strobe  <= w_strobe;
      r_lane    <= w_lane;
    end
  end

  always_comb begin
    w_nxt      = {r_sh[6:0], data_in};
    w_is_com   = (w_nxt == COM);
    w_boundary = (r_bit_cnt == 3'd7);
    w_win_inc  = r_window + 8'd1;
    w_com_inc  = r_com_cnt + 4'd1;
    w_state    = r_state;
    w_bit_cnt  = r_bit_cnt;
    w_window   = r_window;
    w_com_cnt  = r_com_cnt;
    w_active   = r_active;
    w_valid    = r_valid;
    w_data     = r_data;
    w_strobe   = 1'b0;
    w_lane     = r_lane;
    case (r_state)
      HUNT: begin
        w_active = 1'b0;
        w_valid  = 1'b0;
        if (w_is_com) begin
          w_state   = CHECK;
          w_bit_cnt = 3'd0;
          w_com_cnt = 4'd1;
        end
      end
      CHECK: begin
        w_bit_cnt = r_bit_cnt + 3'd1;
        if (w_boundary) begin
          if (w_is_com) begin
            w_com_cnt = w_com_inc;
            if (w_com_inc == LOCK_CNT4) begin
              w_state  = LOCKED;
              w_active = 1'b1;
              w_lane   = 2'd0;
              w_window = 8'h00;
            end
          end else begin
            w_state   = HUNT;
            w_com_cnt = 4'd0;
          end
        end
      end
      LOCKED: begin
        w_bit_cnt = r_bit_cnt + 3'd1;
        if (w_boundary) begin
          // Expiring byte is swallowed: no strobe, data_out keeps the last byte.
          if (!w_is_com && (w_win_inc == WIN8)) begin
            w_state   = HUNT;
            w_active  = 1'b0;
            w_valid   = 1'b0;
            w_lane    = 2'd0;
            w_com_cnt = 4'd0;
            w_window  = 8'h00;
          end else begin
            w_strobe = 1'b1;
            w_data   = w_nxt;
            w_valid  = !w_is_com;
            // Lane advances only once the previous byte on data_out was data.
            w_lane   = r_lane + {1'b0, r_valid};
            if (w_is_com) begin
              w_window  = 8'h00;
              w_com_cnt = (r_com_cnt == 4'd15) ? 4'd15 : w_com_inc;
            end else begin
              w_window  = w_win_inc;
              w_com_cnt = 4'd0;
            end
          end
        end
      end
      default: w_state = HUNT;
    endcase
  end

  assign active      = r_active;
  assign valid       = r_valid;
  assign data_out    = r_data;
  assign byte_strobe = r_strobe;
  assign lane_sel    = r_lane;
  assign com_cnt     = r_com_cnt;

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Bench for phy_rx_sync_ctrl: directed scenarios plus random serial traffic,
// checked each cycle against a bit-history model and pinned literal values.
module tb_phy_rx_sync_ctrl;
  localparam logic [7:0] COM        = 8'hBC;
  localparam int         LOCK_COUNT = 4;
  localparam int         WINDOW     = 16;

  logic       clk_32f = 1'b0;
  logic       default_values = 1'b1;
  logic       data_in = 1'b0;
  logic       active, valid, byte_strobe;
  logic [7:0] data_out;
  logic [1:0] lane_sel;
  logic [3:0] com_cnt;

  phy_rx_sync_ctrl #(.COM(COM), .LOCK_COUNT(LOCK_COUNT), .WINDOW(WINDOW)) dut (
    .clk_32f(clk_32f), .default_values(default_values), .data_in(data_in),
    .active(active), .valid(valid), .data_out(data_out),
    .byte_strobe(byte_strobe), .lane_sel(lane_sel), .com_cnt(com_cnt)
  );

  always #5 clk_32f = ~clk_32f;

  int n_vec = 0;
  int n_bad = 0;
  int ecount = 0;
  logic chk_en = 1'b0;

  // Literal pins: expected value of one output after a given edge number.
  int pin_edge[64];
  int pin_sel[64];
  int pin_exp[64];
  int npins = 0;

  // Model: full bit history since reset, alignment anchor edge, byte counters.
  bit   hist[$];
  int   m_mode, m_anchor, m_ncom, m_win, m_ndata;
  logic m_active, m_valid, m_strobe;
  logic [7:0] m_data;
  logic [1:0] m_lane;

  function automatic string sel_name(input int s);
    case (s)
      0: return "active";
      1: return "valid";
      2: return "data_out";
      3: return "byte_strobe";
      4: return "lane_sel";
      default: return "com_cnt";
    endcase
  endfunction

  always @(negedge clk_32f) begin
    if (chk_en) begin
      n_vec++;
      if ({active, valid, data_out, byte_strobe, lane_sel, com_cnt} !==
          {m_active, m_valid, m_data, m_strobe, m_lane, 4'(m_ncom)}) begin
        n_bad++;
        $display("FAIL model edge %0d: got act=%b vld=%b data=%h stb=%b lane=%0d cc=%0d, want act=%b vld=%b data=%h stb=%b lane=%0d cc=%0d",
                 ecount, active, valid, data_out, byte_strobe, lane_sel, com_cnt,
                 m_active, m_valid, m_data, m_strobe, m_lane, m_ncom);
      end
      for (int i = 0; i < npins; i++) begin
        if (pin_edge[i] == ecount) begin
          logic [7:0] act;
          case (pin_sel[i])
            0: act = {7'd0, active};
            1: act = {7'd0, valid};
            2: act = data_out;
            3: act = {7'd0, byte_strobe};
            4: act = {6'd0, lane_sel};
            default: act = {4'd0, com_cnt};
          endcase
          n_vec++;
          if (act !== 8'(pin_exp[i])) begin
            n_bad++;
            $display("FAIL pin %s edge %0d: got %0h want %0h",
                     sel_name(pin_sel[i]), ecount, act, pin_exp[i]);
          end
        end
      end
    end
  end

  task automatic add_pin(input int edge_n, input int sel, input int exp_v);
    pin_edge[npins] = edge_n;
    pin_sel[npins]  = sel;
    pin_exp[npins]  = exp_v;
    npins++;
  endtask

  task automatic model_step(input bit b, input bit rst);
    logic [7:0] byt;
    int e;
    bit boundary;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < 8; i++) hist.push_back(1'b0);
      m_mode = 0; m_anchor = 0; m_ncom = 0; m_win = 0; m_ndata = 0;
      m_active = 0; m_valid = 0; m_strobe = 0; m_data = 8'h00; m_lane = 0;
      return;
    end
    hist.push_back(b);
    e = hist.size() - 8;
    byt = 8'h00;
    for (int i = 0; i < 8; i++) byt = {byt[6:0], hist[hist.size() - 8 + i]};
    m_strobe = 0;
    boundary = (e > m_anchor) && ((e - m_anchor) % 8 == 0);
    if (m_mode == 0) begin
      m_active = 0; m_valid = 0;
      if (byt == COM) begin
        m_mode = 1; m_anchor = e; m_ncom = 1;
      end
    end else if (m_mode == 1) begin
      if (boundary) begin
        if (byt == COM) begin
          m_ncom++;
          if (m_ncom == LOCK_COUNT) begin
            m_mode = 2; m_active = 1; m_ndata = 0; m_win = 0; m_lane = 0;
          end
        end else begin
          m_mode = 0; m_ncom = 0;
        end
      end
    end else if (boundary) begin
      if (byt != COM && m_win + 1 == WINDOW) begin
        m_mode = 0; m_active = 0; m_valid = 0; m_lane = 0; m_ncom = 0;
      end else begin
        m_strobe = 1; m_data = byt; m_valid = (byt != COM);
        m_lane = 2'(m_ndata % 4);
        if (byt != COM) begin
          m_ndata++; m_win++; m_ncom = 0;
        end else begin
          m_win = 0; m_ncom = (m_ncom >= 15) ? 15 : m_ncom + 1;
        end
      end
    end
  endtask

  task automatic tick(input bit b, input bit rst);
    data_in = b;
    default_values = rst;
    @(posedge clk_32f);
    #1;
    ecount++;
    model_step(b, rst);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) tick(v[i], 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1);
  endtask

  initial begin
    int base;
    chk_en = 1'b1;

    // Lock acquisition
    add_pin(2, 5, 0);
    add_pin(2, 0, 0);
    do_reset(2);
    base = ecount;
    add_pin(base + 8, 5, 1);
    add_pin(base + 31, 0, 0);
    add_pin(base + 32, 0, 1);
    add_pin(base + 32, 5, 4);
    add_pin(base + 32, 3, 0);
    repeat (4) send_byte(COM);

    // Misaligned hunt
    do_reset(2);
    base = ecount;
    add_pin(base + 10, 5, 0);
    add_pin(base + 11, 5, 1);
    add_pin(base + 34, 0, 0);
    add_pin(base + 35, 0, 1);
    tick(1, 0); tick(0, 0); tick(1, 0);
    repeat (4) send_byte(COM);

    // Lock failure in CHECK
    do_reset(2);
    base = ecount;
    add_pin(base + 16, 5, 2);
    add_pin(base + 24, 5, 0);
    add_pin(base + 32, 5, 1);
    add_pin(base + 55, 0, 0);
    add_pin(base + 56, 0, 1);
    send_byte(COM); send_byte(COM); send_byte(8'h55);
    repeat (4) send_byte(COM);

    // Data and lane scheduling
    base = ecount;
    add_pin(base + 8, 2, 8'h11);
    add_pin(base + 8, 3, 1);
    add_pin(base + 9, 3, 0);
    add_pin(base + 16, 4, 1);
    add_pin(base + 24, 1, 0);
    add_pin(base + 24, 4, 2);
    add_pin(base + 32, 4, 2);
    add_pin(base + 48, 2, 8'h55);
    add_pin(base + 48, 4, 0);
    send_byte(8'h11); send_byte(8'h22); send_byte(COM);
    send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);

    // Loss of lock after a COM clears the window
    send_byte(COM);
    base = ecount;
    add_pin(base + 120, 2, 8'hA5);
    add_pin(base + 120, 4, 3);
    add_pin(base + 127, 1, 1);
    add_pin(base + 128, 0, 0);
    add_pin(base + 128, 1, 0);
    add_pin(base + 128, 4, 0);
    add_pin(base + 128, 3, 0);
    add_pin(base + 136, 5, 1);
    repeat (16) send_byte(8'hA5);
    repeat (4) send_byte(COM);

    // Reset mid-byte while locked
    tick(0, 0); tick(1, 0); tick(1, 0);
    base = ecount;
    add_pin(base + 1, 0, 0);
    add_pin(base + 1, 2, 0);
    add_pin(base + 1, 5, 0);
    do_reset(1);
    base = ecount;
    add_pin(base + 31, 0, 0);
    add_pin(base + 32, 0, 1);
    repeat (4) send_byte(COM);

    // Random traffic
    for (int it = 0; it < 250; it++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 8) begin
        repeat ($urandom_range(1, 5)) send_byte(COM);
      end else if (r < 14) begin
        send_byte(8'($urandom));
      end else if (r < 16) begin
        repeat ($urandom_range(1, 7)) tick(1'($urandom), 1'b0);
      end else if (r < 19) begin
        repeat ($urandom_range(3, 18)) begin
          logic [7:0] v;
          v = 8'($urandom);
          if (v == COM) v = v ^ 8'h01;
          send_byte(v);
        end
      end else begin
        do_reset($urandom_range(1, 2));
      end
    end

    chk_en = 1'b0;
    @(negedge clk_32f);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
